// File: rtl/nrs_gen_dbuf_tx.sv
// rtl/nrs_gen_dbuf_tx.sv - double-buffered NB-IoT NRS generator, background fill of shadow bank, swap on subframe strobe
module nrs_gen_dbuf_tx #(
  parameter int WIDTH_B   = 9,
  parameter int NRS_WIDTH = 16,
  parameter logic signed [NRS_WIDTH-1:0] AMP = 16'sd23170,
  parameter int NC         = 1600,
  parameter int SEQ_OFFSET = 218,
  parameter int N_RD       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      new_frame_i,
  input  logic                      new_subframe_i,
  input  logic [WIDTH_B-1:0]        n_cell_id_i,
  input  logic [N_RD*4-1:0]         rd_addr_i,
  output logic [N_RD*NRS_WIDTH-1:0] nrs_out_o,
  output logic                      nrs_valid_o,
  output logic                      gen_busy_o,
  output logic                      overrun_o
);

  typedef enum logic [2:0] {IDLE, LOAD, ADVANCE, CAPTURE, DONE} state_e;

  localparam int ADV = NC + SEQ_OFFSET;
  localparam int CW  = $clog2(ADV + 1);
  localparam logic [NRS_WIDTH-1:0] AMP_P = AMP;
  localparam logic [NRS_WIDTH-1:0] AMP_N = -AMP;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [1:0]               sym_q;
  logic [30:0]              x1_q, x2_q;
  logic [3:0]               target_q, exp_q, tag_q;
  logic [WIDTH_B-1:0]       ncell_q;
  logic                     start_q, done_q, bank_sel_q, valid_q, overrun_q;
  logic [15:0]              bank0_q, bank1_q;
  logic [N_RD*NRS_WIDTH-1:0] nrs_out_q;

  logic                     swap, gen_active, eff_done, c_bit;
  logic [3:0]               exp_d, target_d, eff_tag, wr_idx;
  logic [15:0]              act_bank;
  logic [WIDTH_B-1:0]       n_sel;
  logic [WIDTH_B:0]         n2p1;
  logic [4:0]               ns_w;
  logic [7:0]               t1;
  logic [30:0]              cinit_w;

  assign swap       = new_frame_i | new_subframe_i;
  assign exp_d      = new_frame_i ? 4'd0 : ((exp_q == 4'd9) ? 4'd0 : exp_q + 4'd1);
  assign target_d   = (exp_d == 4'd9) ? 4'd0 : exp_d + 4'd1;
  assign gen_active = (state_q == LOAD) || (state_q == ADVANCE) || (state_q == CAPTURE);
  // A bank completing in DONE this very cycle is treated as finished.
  assign eff_done   = done_q || (state_q == DONE);
  assign eff_tag    = (state_q == DONE) ? target_q : tag_q;
  assign c_bit      = x1_q[0] ^ x2_q[0];
  assign wr_idx     = {sym_q, cnt_q[1:0]};
  assign act_bank   = bank_sel_q ? bank1_q : bank0_q;

  assign n_sel   = (sym_q == 2'd0) ? n_cell_id_i : ncell_q;
  assign n2p1    = {n_sel, 1'b1};
  assign ns_w    = {target_q, sym_q[1]};
  assign t1      = 8'd7 * (8'(ns_w) + 8'd1) + 8'd6 + 8'(sym_q[0]);
  assign cinit_w = ((31'(t1) * 31'(n2p1)) << 10) + 31'(n2p1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      target_q   <= '0;
      exp_q      <= 4'd9;
      tag_q      <= '0;
      ncell_q    <= '0;
      start_q    <= 1'b1;
      done_q     <= 1'b0;
      bank_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      bank0_q    <= '0;
      bank1_q    <= '0;
      nrs_out_q  <= '0;
    end else begin
      overrun_q <= 1'b0;
      x1_q <= {x1_q[3] ^ x1_q[0], x1_q[30:1]};
      x2_q <= {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
      if (swap) begin
        bank_sel_q <= ~bank_sel_q;
        valid_q    <= eff_done && (eff_tag == exp_d);
        done_q     <= 1'b0;
        exp_q      <= exp_d;
        target_q   <= target_d;
        overrun_q  <= gen_active;
        start_q    <= 1'b0;
        state_q    <= LOAD;
        sym_q      <= '0;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_q) begin
              start_q <= 1'b0;
              sym_q   <= '0;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            x1_q  <= 31'd1;
            x2_q  <= cinit_w;
            cnt_q <= '0;
            if (sym_q == 2'd0) ncell_q <= n_cell_id_i;
            state_q <= ADVANCE;
          end
          ADVANCE: begin
            if (cnt_q == CW'(ADV - 1)) begin
              cnt_q   <= '0;
              state_q <= CAPTURE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          CAPTURE: begin
            if (bank_sel_q) bank0_q[wr_idx] <= c_bit;
            else            bank1_q[wr_idx] <= c_bit;
            if (cnt_q[1:0] == 2'd3) begin
              cnt_q <= '0;
              if (sym_q == 2'd3) begin
                state_q <= DONE;
              end else begin
                sym_q   <= sym_q + 2'd1;
                state_q <= LOAD;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            tag_q   <= target_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
      for (int p = 0; p < N_RD; p++) begin
        if (!valid_q)
          nrs_out_q[p*NRS_WIDTH +: NRS_WIDTH] <= '0;
        else if (act_bank[rd_addr_i[4*p +: 4]])
          nrs_out_q[p*NRS_WIDTH +: NRS_WIDTH] <= AMP_N;
        else
          nrs_out_q[p*NRS_WIDTH +: NRS_WIDTH] <= AMP_P;
      end
    end
  end

  assign nrs_out_o   = nrs_out_q;
  assign nrs_valid_o = valid_q;
  assign gen_busy_o  = (state_q != IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_nrs_gen_dbuf_tx.sv
// tb/tb_nrs_gen_dbuf_tx.sv - scoreboard bench for nrs_gen_dbuf_tx with a shortened Gold skip
module tb_nrs_gen_dbuf_tx;

  localparam int NC_TB = 100;
  localparam int OFF   = 218;
  localparam int LAT   = 4 * (1 + NC_TB + OFF + 4) + 1;
  localparam int GAP   = LAT + 200;
  localparam logic [15:0] AMP_P = 16'h5A82;
  localparam logic [15:0] AMP_N = 16'hA57E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_frame, new_subframe;
  logic [8:0]  n_cell;
  logic [15:0] rd_addr;
  logic [63:0] nrs_out;
  logic        nrs_valid, gen_busy, overrun;

  nrs_gen_dbuf_tx #(.NC(NC_TB), .SEQ_OFFSET(OFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .new_frame_i(new_frame), .new_subframe_i(new_subframe),
    .n_cell_id_i(n_cell), .rd_addr_i(rd_addr), .nrs_out_o(nrs_out),
    .nrs_valid_o(nrs_valid), .gen_busy_o(gen_busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [15:0] val; } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_exp, m_start, m_target, m_n_gen;
  logic [15:0] cur_vals [16];

  function automatic logic [3:0] gold(input int n, input int ns, input int l);
    logic [30:0] x1, x2;
    int ci;
    logic [3:0] r;
    ci = (7 * (ns + 1) + l + 1) * (2 * n + 1) * 1024 + 2 * n + 1;
    x1 = 31'd1;
    x2 = ci[30:0];
    for (int i = 0; i < NC_TB + OFF; i++) begin
      x1 = {x1[3] ^ x1[0], x1[30:1]};
      x2 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    end
    for (int b = 0; b < 4; b++) begin
      r[b] = x1[0] ^ x2[0];
      x1 = {x1[3] ^ x1[0], x1[30:1]};
      x2 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic fill_vals(input bit vld, input int tgt, input int n);
    logic [3:0] bits;
    for (int sym = 0; sym < 4; sym++) begin
      bits = gold(n, 2 * tgt + sym / 2, 5 + sym % 2);
      for (int b = 0; b < 4; b++)
        cur_vals[4*sym+b] = !vld ? 16'h0 : (bits[b] ? AMP_N : AMP_P);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    m_start  = cyc;
    m_exp    = 9;
    m_target = 0;
    m_n_gen  = int'(n_cell);
    for (int a = 0; a < 16; a++) cur_vals[a] = 16'h0;
  endtask

  task automatic check_busy_len();
    int cnt = 0;
    while (gen_busy === 1'b1 && cnt < 3 * LAT) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != LAT) begin
      n_fail++;
      $display("FAIL busy_len: got %0d cycles, expected %0d", cnt, LAT);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_checks++;
    if (nrs_out !== 64'h0 || nrs_valid !== 1'b0 || gen_busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: out=%h valid=%b busy=%b ovr=%b, expected all zero", tag, nrs_out, nrs_valid, gen_busy, overrun);
    end
  endtask

  task automatic wait_gap(input int g);
    while (cyc - m_start < g) tick();
  endtask

  task automatic do_strobe(input bit fr, input bit sf);
    int new_exp, el;
    bit vp, op;
    new_exp = fr ? 0 : (m_exp + 1) % 10;
    new_frame = fr;
    new_subframe = sf;
    tick();
    new_frame = 1'b0;
    new_subframe = 1'b0;
    el = cyc - m_start;
    vp = (el >= LAT - 1) && (m_target == new_exp);
    op = (el < LAT - 1);
    n_checks++;
    if (overrun !== op) begin
      n_fail++;
      $display("FAIL overrun sf%0d: got %b, expected %b", new_exp, overrun, op);
    end
    n_checks++;
    if (nrs_valid !== vp) begin
      n_fail++;
      $display("FAIL nrs_valid sf%0d: got %b, expected %b", new_exp, nrs_valid, vp);
    end
    fill_vals(vp, m_target, m_n_gen);
    m_exp    = new_exp;
    m_start  = cyc;
    m_target = (new_exp + 1) % 10;
    m_n_gen  = int'(n_cell);
  endtask

  task automatic pop_check(input int p, input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty on port %0d", tag, p);
      return;
    end
    e = sbq.pop_front();
    n_checks++;
    if (nrs_out[p*16 +: 16] !== e.val) begin
      n_fail++;
      $display("FAIL %s sf%0d addr%0d port%0d: got %h, expected %h", tag, m_exp, e.addr, p, nrs_out[p*16 +: 16], e.val);
    end
  endtask

  task automatic read_all(input string tag);
    exp_t e;
    for (int q = 0; q < 4; q++) begin
      for (int p = 0; p < 4; p++) begin
        rd_addr[4*p +: 4] = 4'(4 * q + p);
        e.addr = 4 * q + p;
        e.val  = cur_vals[4*q+p];
        sbq.push_back(e);
      end
      tick();
      for (int p = 0; p < 4; p++) pop_check(p, tag);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    release_reset();
    n_checks++;
    if (gen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL autostart: busy=%b, expected 1", gen_busy);
    end
    check_busy_len();
  endtask

  task automatic test_first_frame();
    wait_gap(GAP);
    do_strobe(1'b1, 1'b0);
    read_all("first_frame");
  endtask

  task automatic test_wrap();
    n_cell = 9'd503;
    for (int k = 0; k < 10; k++) begin
      wait_gap(GAP);
      do_strobe(1'b0, 1'b1);
      read_all("wrap");
    end
  endtask

  task automatic test_overrun();
    wait_gap(600);
    do_strobe(1'b0, 1'b1);
    tick();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_width: got %b, expected 0", overrun);
    end
    read_all("overrun");
    wait_gap(GAP);
    do_strobe(1'b0, 1'b1);
    read_all("recover");
  endtask

  task automatic test_midframe();
    n_cell = 9'd77;
    wait_gap(GAP);
    do_strobe(1'b0, 1'b1);
    read_all("pre_mid");
    wait_gap(GAP);
    do_strobe(1'b1, 1'b0);
    read_all("midframe");
    wait_gap(GAP);
    do_strobe(1'b0, 1'b1);
    read_all("after_mid");
  endtask

  task automatic test_ports();
    int addrs [4] = '{0, 5, 10, 15};
    exp_t e;
    wait_gap(GAP);
    for (int p = 0; p < 4; p++) begin
      rd_addr[4*p +: 4] = 4'(addrs[p]);
      e.addr = addrs[p];
      e.val  = cur_vals[addrs[p]];
      sbq.push_back(e);
    end
    do_strobe(1'b0, 1'b1);
    for (int p = 0; p < 4; p++) pop_check(p, "swap_cycle");
    for (int p = 0; p < 4; p++) begin
      e.addr = addrs[p];
      e.val  = cur_vals[addrs[p]];
      sbq.push_back(e);
    end
    tick();
    for (int p = 0; p < 4; p++) pop_check(p, "ports");
  endtask

  task automatic test_reset_mid();
    n_cell = 9'd250;
    wait_gap(300);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    release_reset();
    check_busy_len();
    wait_gap(GAP);
    do_strobe(1'b1, 1'b0);
    read_all("after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    new_frame = 1'b0;
    new_subframe = 1'b0;
    n_cell = 9'd0;
    rd_addr = 16'h0;
    test_reset();
    test_first_frame();
    test_wrap();
    test_overrun();
    test_midframe();
    test_ports();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
